// File: rtl/decode_queue.sv
// Decoupling FIFO between the decode mux and dispatch/rename: buffers decoded
// instructions in program order, presents the oldest under a valid/stall handshake.
module decode_queue #(
    parameter int addressWidth            = 64,
    parameter int opcodeSize              = 12,
    parameter int funcUnitCodeSize        = 3,
    parameter int instructionCounterWidth = 64,
    parameter int instMinIdWidth          = 7,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int regAccessPatternSize    = 2,
    parameter int bodyWidth               = 64,
    parameter int queueDepth              = 8,
    parameter int queueIndexWidth         = 3
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               flush_i,

    input  logic                               enable_i,
    input  logic [opcodeSize-1:0]              opcode_i,
    input  logic [addressWidth-1:0]            address_i,
    input  logic [funcUnitCodeSize-1:0]        funcUnitType_i,
    input  logic [instructionCounterWidth-1:0] majID_i,
    input  logic [instMinIdWidth-1:0]          minID_i,
    input  logic [instMinIdWidth-1:0]          numMicroOps_i,
    input  logic                               is64Bit_i,
    input  logic [PidSize-1:0]                 pid_i,
    input  logic [TidSize-1:0]                 tid_i,
    input  logic [regAccessPatternSize-1:0]    op1rw_i,
    input  logic [regAccessPatternSize-1:0]    op2rw_i,
    input  logic [regAccessPatternSize-1:0]    op3rw_i,
    input  logic [regAccessPatternSize-1:0]    op4rw_i,
    input  logic                               op1IsReg_i,
    input  logic                               op2IsReg_i,
    input  logic                               op3IsReg_i,
    input  logic                               op4IsReg_i,
    input  logic                               modifiesCR_i,
    input  logic [bodyWidth-1:0]               body_i,
    output logic                               full_o,

    output logic                               enable_o,
    output logic [opcodeSize-1:0]              opcode_o,
    output logic [addressWidth-1:0]            address_o,
    output logic [funcUnitCodeSize-1:0]        funcUnitType_o,
    output logic [instructionCounterWidth-1:0] majID_o,
    output logic [instMinIdWidth-1:0]          minID_o,
    output logic [instMinIdWidth-1:0]          numMicroOps_o,
    output logic                               is64Bit_o,
    output logic [PidSize-1:0]                 pid_o,
    output logic [TidSize-1:0]                 tid_o,
    output logic [regAccessPatternSize-1:0]    op1rw_o,
    output logic [regAccessPatternSize-1:0]    op2rw_o,
    output logic [regAccessPatternSize-1:0]    op3rw_o,
    output logic [regAccessPatternSize-1:0]    op4rw_o,
    output logic                               op1IsReg_o,
    output logic                               op2IsReg_o,
    output logic                               op3IsReg_o,
    output logic                               op4IsReg_o,
    output logic                               modifiesCR_o,
    output logic [bodyWidth-1:0]               body_o,
    input  logic                               stall_i,
    output logic [queueIndexWidth:0]           count_o
);

    localparam int PW = opcodeSize + addressWidth + funcUnitCodeSize + instructionCounterWidth
                      + 2 * instMinIdWidth + 1 + PidSize + TidSize
                      + 4 * regAccessPatternSize + 4 + 1 + bodyWidth;
    localparam int CW = queueIndexWidth + 1;
    localparam logic [CW-1:0] DEPTH = CW'(queueDepth);

    logic [PW-1:0]              mem_q [queueDepth];
    logic [queueIndexWidth-1:0] wp_q, wp_d;
    logic [queueIndexWidth-1:0] rp_q, rp_d;
    logic [CW-1:0]              count_q, count_d;
    logic                       push, pop;
    logic [PW-1:0]              wr_data, rd_data;

    assign wr_data = {opcode_i, address_i, funcUnitType_i, majID_i, minID_i, numMicroOps_i,
                      is64Bit_i, pid_i, tid_i, op1rw_i, op2rw_i, op3rw_i, op4rw_i,
                      op1IsReg_i, op2IsReg_i, op3IsReg_i, op4IsReg_i, modifiesCR_i, body_i};

    // Status comes from registered count only, so a pop never frees a slot for the same-cycle push.
    assign full_o   = (count_q == DEPTH);
    assign enable_o = (count_q != '0);
    assign count_o  = count_q;

    assign push = enable_i && !full_o;
    assign pop  = enable_o && !stall_i;

    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (push) begin
            wp_d = wp_q + queueIndexWidth'(1);
        end
        if (pop) begin
            rp_d = rp_q + queueIndexWidth'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i || flush_i) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

    // Array contents are don't-care after reset/flush, so storage carries no reset.
    always_ff @(posedge clock_i) begin
        if (push && !reset_i && !flush_i) begin
            mem_q[wp_q] <= wr_data;
        end
    end

    assign rd_data = enable_o ? mem_q[rp_q] : '0;

    assign {opcode_o, address_o, funcUnitType_o, majID_o, minID_o, numMicroOps_o,
            is64Bit_o, pid_o, tid_o, op1rw_o, op2rw_o, op3rw_o, op4rw_o,
            op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o, modifiesCR_o, body_o} = rd_data;

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: scoreboard of expected majIDs plus
// per-scenario tasks with inline comparisons.
module tb_decode_queue;

    logic        clk = 1'b0;
    logic        reset_i = 1'b0, flush_i = 1'b0, enable_i = 1'b0, stall_i = 1'b1;
    logic [11:0] opcode_i = '0;
    logic [63:0] address_i = '0;
    logic [2:0]  funcUnitType_i = '0;
    logic [63:0] majID_i = '0;
    logic [6:0]  minID_i = '0, numMicroOps_i = '0;
    logic        is64Bit_i = 1'b0;
    logic [19:0] pid_i = '0;
    logic [15:0] tid_i = '0;
    logic [1:0]  op1rw_i = '0, op2rw_i = '0, op3rw_i = '0, op4rw_i = '0;
    logic        op1IsReg_i = 1'b0, op2IsReg_i = 1'b0, op3IsReg_i = 1'b0, op4IsReg_i = 1'b0;
    logic        modifiesCR_i = 1'b0;
    logic [63:0] body_i = '0;

    logic        full_o, enable_o;
    logic [11:0] opcode_o;
    logic [63:0] address_o;
    logic [2:0]  funcUnitType_o;
    logic [63:0] majID_o;
    logic [6:0]  minID_o, numMicroOps_o;
    logic        is64Bit_o;
    logic [19:0] pid_o;
    logic [15:0] tid_o;
    logic [1:0]  op1rw_o, op2rw_o, op3rw_o, op4rw_o;
    logic        op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o, modifiesCR_o;
    logic [63:0] body_o;
    logic [3:0]  count_o;

    int tests_run = 0;
    int tests_failed = 0;
    longint unsigned exp_q[$];
    int mcount = 0;

    always #5 clk = ~clk;

    decode_queue dut (
        .clock_i(clk), .reset_i(reset_i), .flush_i(flush_i), .enable_i(enable_i),
        .opcode_i(opcode_i), .address_i(address_i), .funcUnitType_i(funcUnitType_i),
        .majID_i(majID_i), .minID_i(minID_i), .numMicroOps_i(numMicroOps_i),
        .is64Bit_i(is64Bit_i), .pid_i(pid_i), .tid_i(tid_i),
        .op1rw_i(op1rw_i), .op2rw_i(op2rw_i), .op3rw_i(op3rw_i), .op4rw_i(op4rw_i),
        .op1IsReg_i(op1IsReg_i), .op2IsReg_i(op2IsReg_i), .op3IsReg_i(op3IsReg_i),
        .op4IsReg_i(op4IsReg_i), .modifiesCR_i(modifiesCR_i), .body_i(body_i),
        .full_o(full_o), .enable_o(enable_o), .opcode_o(opcode_o), .address_o(address_o),
        .funcUnitType_o(funcUnitType_o), .majID_o(majID_o), .minID_o(minID_o),
        .numMicroOps_o(numMicroOps_o), .is64Bit_o(is64Bit_o), .pid_o(pid_o), .tid_o(tid_o),
        .op1rw_o(op1rw_o), .op2rw_o(op2rw_o), .op3rw_o(op3rw_o), .op4rw_o(op4rw_o),
        .op1IsReg_o(op1IsReg_o), .op2IsReg_o(op2IsReg_o), .op3IsReg_o(op3IsReg_o),
        .op4IsReg_o(op4IsReg_o), .modifiesCR_o(modifiesCR_o), .body_o(body_o),
        .stall_i(stall_i), .count_o(count_o)
    );

    // Drive one cycle, advance the reference model, return at the next falling edge.
    task automatic tick(input bit rst, input bit fl, input bit en, input longint unsigned maj,
                        input bit st);
        bit mpush, mpop;
        reset_i  = rst;
        flush_i  = fl;
        enable_i = en;
        majID_i  = maj;
        stall_i  = st;
        if (rst || fl) begin
            exp_q.delete();
            mcount = 0;
        end else begin
            mpush = en && (mcount < 8);
            mpop  = (mcount != 0) && !st;
            if (mpop) void'(exp_q.pop_front());
            if (mpush) exp_q.push_back(maj);
            mcount = mcount + (mpush ? 1 : 0) - (mpop ? 1 : 0);
        end
        @(posedge clk);
        @(negedge clk);
        reset_i  = 1'b0;
        flush_i  = 1'b0;
        enable_i = 1'b0;
    endtask

    task automatic test_reset();
        tick(1, 0, 0, 0, 1);
        tests_run++;
        if (enable_o !== 1'b0 || full_o !== 1'b0 || count_o !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_status: enable=%b full=%b count=%0d expected 0 0 0",
                     enable_o, full_o, count_o);
        end
        tests_run++;
        if (majID_o !== 64'd0 || body_o !== 64'd0 || opcode_o !== 12'd0 || address_o !== 64'd0) begin
            tests_failed++;
            $display("FAIL reset_payload: majID=%0d body=%h opcode=%h addr=%h expected all zero",
                     majID_o, body_o, opcode_o, address_o);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            tick(0, 0, 1, longint'(i), 1);
            tests_run++;
            if (count_o !== 4'(i + 1) || majID_o !== 64'd0 || full_o !== (i == 7)) begin
                tests_failed++;
                $display("FAIL fill_%0d: count=%0d head=%0d full=%b expected %0d 0 %b",
                         i, count_o, majID_o, full_o, i + 1, (i == 7));
            end
        end
    endtask

    task automatic test_overflow();
        tick(0, 0, 1, 99, 1);
        tests_run++;
        if (count_o !== 4'd8 || full_o !== 1'b1 || majID_o !== 64'd0) begin
            tests_failed++;
            $display("FAIL overflow_hold: count=%0d full=%b head=%0d expected 8 1 0",
                     count_o, full_o, majID_o);
        end
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (enable_o !== 1'b1 || majID_o !== exp_q[0]) begin
                tests_failed++;
                $display("FAIL overflow_pop_%0d: enable=%b head=%0d expected 1 %0d",
                         i, enable_o, majID_o, exp_q[0]);
            end
            tick(0, 0, 0, 0, 0);
        end
        tests_run++;
        if (count_o !== 4'd0 || enable_o !== 1'b0 || majID_o !== 64'd0 || body_o !== 64'd0) begin
            tests_failed++;
            $display("FAIL overflow_drained: count=%0d enable=%b head=%0d body=%h expected 0 0 0 0",
                     count_o, enable_o, majID_o, body_o);
        end
    endtask

    task automatic test_stream();
        tick(0, 0, 1, 100, 0);
        for (int k = 1; k <= 20; k++) begin
            tests_run++;
            if (enable_o !== 1'b1 || majID_o !== 64'(100 + k - 1) || count_o !== 4'd1) begin
                tests_failed++;
                $display("FAIL stream_%0d: enable=%b head=%0d count=%0d expected 1 %0d 1",
                         k, enable_o, majID_o, count_o, 100 + k - 1);
            end
            if (k < 20) tick(0, 0, 1, longint'(100 + k), 0);
            else        tick(0, 0, 0, 0, 0);
        end
        tests_run++;
        if (count_o !== 4'd0 || enable_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL stream_drain: count=%0d enable=%b expected 0 0", count_o, enable_o);
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 8; i++) tick(0, 0, 1, longint'(200 + i), 1);
        tick(0, 0, 1, 50, 0);
        tests_run++;
        if (count_o !== 4'd7 || full_o !== 1'b0 || majID_o !== 64'd201) begin
            tests_failed++;
            $display("FAIL full_pushpop: count=%0d full=%b head=%0d expected 7 0 201",
                     count_o, full_o, majID_o);
        end
        while (exp_q.size() != 0) begin
            tests_run++;
            if (majID_o !== exp_q[0] || majID_o === 64'd50) begin
                tests_failed++;
                $display("FAIL full_pushpop_drain: head=%0d expected %0d", majID_o, exp_q[0]);
            end
            tick(0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) tick(0, 0, 1, longint'(300 + i), 1);
        tests_run++;
        if (count_o !== 4'd5) begin
            tests_failed++;
            $display("FAIL flush_prefill: count=%0d expected 5", count_o);
        end
        tick(0, 1, 1, 77, 0);
        tests_run++;
        if (count_o !== 4'd0 || enable_o !== 1'b0 || majID_o !== 64'd0) begin
            tests_failed++;
            $display("FAIL flush_clear: count=%0d enable=%b head=%0d expected 0 0 0",
                     count_o, enable_o, majID_o);
        end
        tick(0, 0, 1, 7, 1);
        tests_run++;
        if (count_o !== 4'd1 || majID_o !== 64'd7) begin
            tests_failed++;
            $display("FAIL flush_next_push: count=%0d head=%0d expected 1 7", count_o, majID_o);
        end
        tick(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) tick(0, 0, 1, longint'(400 + i), 1);
        tick(1, 0, 1, 55, 0);
        tests_run++;
        if (count_o !== 4'd0 || enable_o !== 1'b0 || majID_o !== 64'd0) begin
            tests_failed++;
            $display("FAIL reset_mid: count=%0d enable=%b head=%0d expected 0 0 0",
                     count_o, enable_o, majID_o);
        end
    endtask

    task automatic test_payload();
        opcode_i = 12'd4;  funcUnitType_i = 3'd1;  address_i = 64'h0000_1000_2000_3004;
        minID_i = 7'd5;    numMicroOps_i = 7'd2;   is64Bit_i = 1'b1;
        pid_i = 20'hABCDE; tid_i = 16'h1234;
        op1rw_i = 2'b01;   op2rw_i = 2'b10;  op3rw_i = 2'b00;  op4rw_i = 2'b10;
        op1IsReg_i = 1'b1; op2IsReg_i = 1'b1; op3IsReg_i = 1'b0; op4IsReg_i = 1'b1;
        modifiesCR_i = 1'b1; body_i = 64'h8BBE_0800_0000_0000;
        tick(0, 0, 1, 500, 1);
        opcode_i = '0; funcUnitType_i = '0; address_i = '0; body_i = '0; pid_i = '0; tid_i = '0;
        tests_run++;
        if (opcode_o !== 12'd4 || funcUnitType_o !== 3'd1 || address_o !== 64'h0000_1000_2000_3004
            || majID_o !== 64'd500 || body_o !== 64'h8BBE_0800_0000_0000) begin
            tests_failed++;
            $display("FAIL payload_ident: opc=%0d fu=%0d addr=%h maj=%0d body=%h",
                     opcode_o, funcUnitType_o, address_o, majID_o, body_o);
        end
        tests_run++;
        if (minID_o !== 7'd5 || numMicroOps_o !== 7'd2 || is64Bit_o !== 1'b1
            || pid_o !== 20'hABCDE || tid_o !== 16'h1234 || modifiesCR_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL payload_ids: min=%0d nmu=%0d is64=%b pid=%h tid=%h cr=%b",
                     minID_o, numMicroOps_o, is64Bit_o, pid_o, tid_o, modifiesCR_o);
        end
        tests_run++;
        if ({op1rw_o, op2rw_o, op3rw_o, op4rw_o} !== 8'b01_10_00_10
            || {op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o} !== 4'b1101) begin
            tests_failed++;
            $display("FAIL payload_ops: rw=%b isreg=%b expected 01100010 1101",
                     {op1rw_o, op2rw_o, op3rw_o, op4rw_o},
                     {op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o});
        end
        tick(0, 0, 0, 0, 0);
        tests_run++;
        if (enable_o !== 1'b0 || body_o !== 64'd0 || opcode_o !== 12'd0) begin
            tests_failed++;
            $display("FAIL payload_gate: enable=%b body=%h opc=%h expected 0 0 0",
                     enable_o, body_o, opcode_o);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_stream();
        test_full_push_pop();
        test_flush();
        test_reset_mid();
        test_payload();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/decode_queue.md
# decode_queue

Decoupling FIFO between the decode mux and the dispatch/rename stage. It captures each decoded instruction the mux presents, buffers up to `queueDepth` of them in program order, and presents the oldest entry downstream under a valid/stall handshake. Backpressure is returned to decode through `full_o`. A synchronous flush discards all buffered work on branch mispredict or exception.

## Interface
**Parameters** (name, default, meaning):
- `addressWidth`, 64, instruction address width.
- `opcodeSize`, 12, internal opcode width.
- `funcUnitCodeSize`, 3, functional-unit code width.
- `instructionCounterWidth`, 64, major ID width.
- `instMinIdWidth`, 7, minor ID and micro-op count width.
- `PidSize`, 20, process ID width.
- `TidSize`, 16, thread ID width.
- `regAccessPatternSize`, 2, per-operand read/write flags; `2'b10` = read, `2'b01` = write.
- `bodyWidth`, 64, operand body width.
- `queueDepth`, 8, number of entries; must be a power of two, ≥ 2.
- `queueIndexWidth`, 3, log2(`queueDepth`).

**Ports** (name, direction, width, meaning):
- `clock_i` in 1: single clock; all state updates on the rising edge.
- `reset_i` in 1: synchronous, active-high.
- `flush_i` in 1: synchronous, active-high; empties the queue.
- `enable_i` in 1: decode mux output valid.
- `opcode_i`, `address_i`, `funcUnitType_i`, `majID_i`, `minID_i`, `numMicroOps_i`, `is64Bit_i`, `pid_i`, `tid_i` in (parameter widths): instruction identity fields.
- `op1rw_i`..`op4rw_i` in 2 each: operand access patterns.
- `op1IsReg_i`..`op4IsReg_i` in 1 each: operand is a register.
- `modifiesCR_i` in 1: instruction writes the condition register.
- `body_i` in `bodyWidth`: operand body.
- `full_o` out 1: queue full; decode must hold.
- `enable_o` out 1: head entry valid.
- `opcode_o` … `body_o` out: head-entry copies of every `_i` payload field, same widths.
- `stall_i` in 1: downstream cannot accept the head this cycle.
- `count_o` out `queueIndexWidth`+1: number of occupied entries.

## Operation
- **Storage:** circular array of `queueDepth` entries. Write pointer `wp`, read pointer `rp` (each `queueIndexWidth` bits, wrapping modulo depth), and a `count` register.
- **Push:** occurs when `enable_i && !full_o`. The payload is written at `wp` and `wp` increments.
- **Push while full:** if `enable_i && full_o`, the input is ignored. State is unchanged and no entry is overwritten.
- **Pop:** occurs when `enable_o && !stall_i`. `rp` increments.
- **Simultaneous push and pop:** both occur and `count` is unchanged. Push-while-full is never accepted in the same cycle as a pop (no bypass); `full_o` is computed from the registered count only.
- **Count update:** `count_next = count + push − pop`. `count` never exceeds `queueDepth` and never underflows.
- **Status outputs:** `full_o = (count == queueDepth)`, `enable_o = (count != 0)`, `count_o = count`.
- **Payload gating:** payload outputs show the entry at `rp` when `enable_o = 1`, and are forced to all-zero when `enable_o = 0`.
- **Flush:** `flush_i` sets `wp = rp = count = 0` at the edge. A push or pop requested in the same cycle is discarded.
- **Priority:** `reset_i` > `flush_i` > push/pop.
- **Ordering:** strict FIFO. Fields are stored bit-exact with no modification.

## Timing
- **Reset values:** on the edge with `reset_i = 1`, `count = wp = rp = 0`. In the following cycle `enable_o = 0`, `full_o = 0`, `count_o = 0`, and all payload outputs are 0. Array contents are don't-care.
- **Reset mid-operation:** all buffered entries are lost. No output pulse occurs.
- **Latency:**
  - An entry pushed at edge N is visible on `enable_o`/payload after edge N (combinational read of the registered array).
  - It can pop at edge N+1 at the earliest.
- **Throughput:** one push and one pop per cycle sustained.
- **`full_o`:** reflects the state after the last edge. It deasserts in the cycle after a pop from full.
- **Stalled head:** while `stall_i = 1`, the head payload and `enable_o` stay stable.
- **Wrap-around:** pointers roll from `queueDepth−1` to 0 with no bubble.

## Test plan
- **Reset, then fill:**
  - Stimulus: reset, then push 8 entries with `majID_i` = 0..7 and `stall_i = 1`.
  - Required: `count_o` steps 1..8; `full_o = 1` after the 8th edge; the head shows `majID` 0 throughout.
- **Overflow attempt:**
  - Stimulus: with the queue full, push `majID_i = 99`, then release the stall.
  - Required: the pops yield `majID` 0..7 in order; 99 never appears; `count_o` returns to 0; `enable_o` = 0 with zeroed payload.
- **Streaming with wrap:**
  - Stimulus: push and pop every cycle for 20 cycles (`majID_i` = 100..119).
  - Required: outputs 100..119 in order, each one cycle after its push; `count_o` stays at 1 after the first cycle.
- **Simultaneous push and pop at full:**
  - Stimulus: queue full, `stall_i = 0`, `enable_i = 1` with `majID_i = 50`.
  - Required: the head pops; 50 is dropped; `count_o` = 7; `full_o` = 0 in the next cycle.
- **Flush:**
  - Stimulus: with 5 entries queued, assert `flush_i` together with `enable_i`.
  - Required: next cycle `count_o` = 0, `enable_o` = 0; the next push (`majID_i = 7`) appears as the head.
- **Payload fidelity:**
  - Stimulus: push an FP multiply with `opcode_i = 4`, `funcUnitType_i = 1`, `op1rw_i = 2'b01`, `op2rw_i = 2'b10`, `op4rw_i = 2'b10`, `op1IsReg_i`/`op2IsReg_i`/`op4IsReg_i` = 1, `body_i = 64'h8BBE_0800_0000_0000`.
  - Required: every output field matches the pushed value exactly.
